// File: rtl/cpu_pkg.sv
// Shared definitions for the simple 8-bit core: opcodes, ALU operations and branch/operand controls.
// Also holds the branch displacement helper used by the next-PC logic.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2
    } branch_e;

    typedef enum logic [1:0] {
        OP2_REG = 2'd0,
        OP2_NEG = 2'd1,
        OP2_IMM = 2'd2
    } op2_sel_e;

    typedef struct packed {
        logic     reg_write;
        logic     jump;
        branch_e  branch;
        alu_op_e  alu_op;
        op2_sel_e op2_sel;
    } ctrl_t;

    // Offset counts instructions, so it is sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_disp(input logic [7:0] off);
        return {{22{off[7]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/simple_cpu_core_if.sv
// Instruction fetch port between the core and external instruction memory.
// No handshake: memory returns INSTRUCTION for PC_OUT combinationally and it is always valid.
interface simple_cpu_core_if;
    logic [31:0] PC_OUT;
    logic [31:0] INSTRUCTION;

    modport master (output PC_OUT, input INSTRUCTION);
    modport slave  (input PC_OUT, output INSTRUCTION);
endinterface

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU with zero flag; unknown operation codes yield zero.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [7:0] operand1,
    input  logic [7:0] operand2,
    output logic [7:0] result,
    output logic       zero
);

    always_comb begin
        result = 8'h00;
        case (alu_op)
            ALU_FWD: result = operand2;
            ALU_ADD: result = operand1 + operand2;
            ALU_AND: result = operand1 & operand2;
            ALU_OR:  result = operand1 | operand2;
            default: result = 8'h00;
        endcase
    end

    assign zero = (result == 8'h00);

endmodule

// File: rtl/cpu_decode.sv
// Opcode decoder: maps the 8-bit opcode to write enable, ALU operation, operand-2 source and branch control.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.alu_op  = ALU_FWD;
        ctrl.op2_sel = OP2_REG;
        ctrl.branch  = BR_NONE;
        case (opcode)
            OP_LOADI: begin
                ctrl.reg_write = 1'b1;
                ctrl.op2_sel   = OP2_IMM;
            end
            OP_MOV: ctrl.reg_write = 1'b1;
            OP_ADD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.op2_sel   = OP2_NEG;
            end
            OP_AND: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_AND;
            end
            OP_OR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_OR;
            end
            OP_J: ctrl.jump = 1'b1;
            // Conditional branches compare by subtracting and testing ZERO.
            OP_BEQ: begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.op2_sel = OP2_NEG;
                ctrl.branch  = BR_BEQ;
            end
            OP_BNE: begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.op2_sel = OP2_NEG;
                ctrl.branch  = BR_BNE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_regfile.sv
// 8x8 register file: two combinational read ports, one write port committed on the rising edge.
// A read of the register being written in the same cycle sees the old value.
module cpu_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr1,
    input  logic [2:0] raddr2,
    output logic [7:0] rdata1,
    output logic [7:0] rdata2
);

    logic [7:0] regs [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/simple_cpu_core.sv
// Single-cycle 8-bit core: PC and next-PC logic here, decode/regfile/ALU in sub-modules.
// Every instruction fetched via the fetch interface commits its write and PC change on the next edge.
module simple_cpu_core
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    simple_cpu_core_if.master         imem,
    output logic [7:0]                ALU_RESULT,
    output logic                      ZERO
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr;
    ctrl_t       ctrl;
    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic [7:0]  operand2;
    logic        taken;
    logic        unused_instr_bits;

    assign instr             = imem.INSTRUCTION;
    assign unused_instr_bits = ^{instr[23:19], instr[15:11]};

    cpu_decode u_decode (
        .opcode (instr[7:0]),
        .ctrl   (ctrl)
    );

    cpu_regfile u_regfile (
        .clk    (CLK),
        .rst_n  (RESET),
        .we     (ctrl.reg_write),
        .waddr  (instr[10:8]),
        .wdata  (ALU_RESULT),
        .raddr1 (instr[18:16]),
        .raddr2 (instr[26:24]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        operand2 = rs2_data;
        case (ctrl.op2_sel)
            OP2_NEG: operand2 = ~rs2_data + 8'd1;
            OP2_IMM: operand2 = instr[31:24];
            default: operand2 = rs2_data;
        endcase
    end

    cpu_alu u_alu (
        .alu_op   (ctrl.alu_op),
        .operand1 (rs1_data),
        .operand2 (operand2),
        .result   (ALU_RESULT),
        .zero     (ZERO)
    );

    always_comb begin
        taken = ctrl.jump
              | ((ctrl.branch == BR_BEQ) &  ZERO)
              | ((ctrl.branch == BR_BNE) & ~ZERO);
    end

    assign pc_plus4 = pc + 32'd4;
    assign pc_next  = taken ? (pc_plus4 + branch_disp(instr[15:8])) : pc_plus4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign imem.PC_OUT = pc;

endmodule

// File: tb/tb_simple_cpu_core.sv
// Directed bench for simple_cpu_core: the bench plays instruction memory and peeks registers
// through a combinational mov during the clock low phase, before any edge can commit it.
module tb_simple_cpu_core;
    import cpu_pkg::*;

    logic       CLK;
    logic       RESET;
    logic [7:0] ALU_RESULT;
    logic       ZERO;
    int         n_checks;
    int         n_fail;

    simple_cpu_core_if bus();

    simple_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .imem       (bus),
        .ALU_RESULT (ALU_RESULT),
        .ZERO       (ZERO)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, op};
    endfunction

    task automatic wait_low();
        @(negedge CLK);
    endtask

    task automatic drive(input logic [31:0] instr);
        bus.INSTRUCTION = instr;
        #1;
    endtask

    task automatic commit();
        @(posedge CLK);
        #1;
    endtask

    // Must be called in the low phase and followed by a drive() before the next edge.
    task automatic peek(input logic [2:0] r, output logic [7:0] v);
        bus.INSTRUCTION = mk(OP_MOV, 8'h00, 8'h00, {5'b0, r});
        #1;
        v = ALU_RESULT;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        RESET = 1'b0;
        bus.INSTRUCTION = mk(OP_LOADI, 8'h01, 8'h00, 8'hAA);
        commit();
        commit();
        n_checks++; if (dut.imem.PC_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.PC_OUT, 32'h0); end
        wait_low();
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), v);
            n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
        end
        RESET = 1'b1;
        drive(mk(OP_LOADI, 8'h01, 8'h00, 8'h05));
    endtask

    task automatic test_loadi_add();
        logic [7:0] v;
        // loadi r1,5 is already driven from the reset release low phase
        n_checks++; if (ALU_RESULT !== 8'h05) begin n_fail++; $display("FAIL loadi1_alu: got %h expected 05", ALU_RESULT); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd4) begin n_fail++; $display("FAIL loadi1_pc: got %h expected 4", bus.PC_OUT); end
        wait_low(); drive(mk(OP_LOADI, 8'h02, 8'h00, 8'h03));
        n_checks++; if (ALU_RESULT !== 8'h03) begin n_fail++; $display("FAIL loadi2_alu: got %h expected 03", ALU_RESULT); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd8) begin n_fail++; $display("FAIL loadi2_pc: got %h expected 8", bus.PC_OUT); end
        wait_low(); drive(mk(OP_ADD, 8'h03, 8'h01, 8'h02));
        n_checks++; if (ALU_RESULT !== 8'h08 || ZERO !== 1'b0) begin n_fail++; $display("FAIL add_alu: got %h/%b expected 08/0", ALU_RESULT, ZERO); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd12) begin n_fail++; $display("FAIL add_pc: got %h expected c", bus.PC_OUT); end
        wait_low(); peek(3'd3, v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL add_r3: got %h expected 08", v); end
    endtask

    task automatic test_logic_ops();
        logic [7:0] v;
        drive(mk(OP_SUB, 8'h04, 8'h02, 8'h01));
        n_checks++; if (ALU_RESULT !== 8'hFE || ZERO !== 1'b0) begin n_fail++; $display("FAIL sub_alu: got %h/%b expected fe/0", ALU_RESULT, ZERO); end
        commit();
        wait_low(); drive(mk(OP_LOADI, 8'h06, 8'h00, 8'hF0)); commit();
        wait_low(); drive(mk(OP_LOADI, 8'h07, 8'h00, 8'h3C)); commit();
        wait_low(); drive(mk(OP_AND, 8'h00, 8'h06, 8'h07));
        n_checks++; if (ALU_RESULT !== 8'h30) begin n_fail++; $display("FAIL and_alu: got %h expected 30", ALU_RESULT); end
        commit();
        wait_low(); drive(mk(OP_OR, 8'h00, 8'h06, 8'h07));
        n_checks++; if (ALU_RESULT !== 8'hFC) begin n_fail++; $display("FAIL or_alu: got %h expected fc", ALU_RESULT); end
        commit();
        wait_low(); drive(mk(OP_MOV, 8'h05, 8'h00, 8'h01));
        n_checks++; if (ALU_RESULT !== 8'h05) begin n_fail++; $display("FAIL mov_alu: got %h expected 05", ALU_RESULT); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd36) begin n_fail++; $display("FAIL ops_pc: got %h expected 24", bus.PC_OUT); end
        wait_low();
        peek(3'd4, v);
        n_checks++; if (v !== 8'hFE) begin n_fail++; $display("FAIL sub_r4: got %h expected fe", v); end
        peek(3'd0, v);
        n_checks++; if (v !== 8'hFC) begin n_fail++; $display("FAIL or_r0: got %h expected fc", v); end
        peek(3'd5, v);
        n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL mov_r5: got %h expected 05", v); end
    endtask

    task automatic test_branch();
        logic [7:0] v;
        // Asynchronous reset in the middle of the program, no clock edge involved
        RESET = 1'b0;
        #1;
        n_checks++; if (bus.PC_OUT !== 32'h0) begin n_fail++; $display("FAIL midreset_pc: got %h expected 0", bus.PC_OUT); end
        peek(3'd4, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL midreset_r4: got %h expected 00", v); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_hold_pc: got %h expected 0", bus.PC_OUT); end
        wait_low(); RESET = 1'b1;
        drive(mk(OP_LOADI, 8'h01, 8'h00, 8'h05)); commit();
        wait_low(); drive(mk(OP_LOADI, 8'h02, 8'h00, 8'h03)); commit();
        wait_low(); drive(mk(8'hFF, 8'h00, 8'h00, 8'h00)); commit();
        wait_low(); drive(mk(8'hFF, 8'h00, 8'h00, 8'h00)); commit();
        n_checks++; if (bus.PC_OUT !== 32'd16) begin n_fail++; $display("FAIL pre_beq_pc: got %h expected 10", bus.PC_OUT); end
        wait_low(); drive(mk(OP_BEQ, 8'h02, 8'h01, 8'h01));
        n_checks++; if (ALU_RESULT !== 8'h00 || ZERO !== 1'b1) begin n_fail++; $display("FAIL beq_eq_alu: got %h/%b expected 00/1", ALU_RESULT, ZERO); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd28) begin n_fail++; $display("FAIL beq_taken_pc: got %h expected 1c", bus.PC_OUT); end
        wait_low(); drive(mk(OP_J, 8'hFC, 8'h00, 8'h00)); commit();
        n_checks++; if (bus.PC_OUT !== 32'd16) begin n_fail++; $display("FAIL j_back_pc: got %h expected 10", bus.PC_OUT); end
        wait_low(); drive(mk(OP_BEQ, 8'h02, 8'h01, 8'h02));
        n_checks++; if (ALU_RESULT !== 8'h02 || ZERO !== 1'b0) begin n_fail++; $display("FAIL beq_ne_alu: got %h/%b expected 02/0", ALU_RESULT, ZERO); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd20) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h expected 14", bus.PC_OUT); end
        wait_low(); drive(mk(OP_J, 8'hFE, 8'h00, 8'h00)); commit();
        wait_low(); drive(mk(OP_BNE, 8'hFE, 8'h01, 8'h02)); commit();
        n_checks++; if (bus.PC_OUT !== 32'd12) begin n_fail++; $display("FAIL bne_taken_pc: got %h expected c", bus.PC_OUT); end
    endtask

    task automatic test_jump_nop();
        logic [7:0] v;
        wait_low(); drive(mk(8'hFF, 8'h01, 8'h01, 8'hAA)); commit();
        n_checks++; if (bus.PC_OUT !== 32'd16) begin n_fail++; $display("FAIL nop_pc: got %h expected 10", bus.PC_OUT); end
        wait_low();
        peek(3'd1, v);
        n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL nop_r1: got %h expected 05", v); end
        peek(3'd2, v);
        n_checks++; if (v !== 8'h03) begin n_fail++; $display("FAIL nop_r2: got %h expected 03", v); end
        RESET = 1'b0; #1; RESET = 1'b1;
        drive(mk(OP_J, 8'h01, 8'h00, 8'h00)); commit();
        n_checks++; if (bus.PC_OUT !== 32'd8) begin n_fail++; $display("FAIL j_fwd_pc: got %h expected 8", bus.PC_OUT); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        wait_low(); drive(mk(OP_LOADI, 8'h01, 8'h00, 8'hFF)); commit();
        wait_low(); drive(mk(OP_LOADI, 8'h02, 8'h00, 8'h01)); commit();
        wait_low(); drive(mk(OP_ADD, 8'h03, 8'h01, 8'h02));
        n_checks++; if (ALU_RESULT !== 8'h00 || ZERO !== 1'b1) begin n_fail++; $display("FAIL add_wrap_alu: got %h/%b expected 00/1", ALU_RESULT, ZERO); end
        commit();
        n_checks++; if (bus.PC_OUT !== 32'd20) begin n_fail++; $display("FAIL add_wrap_pc: got %h expected 14", bus.PC_OUT); end
        wait_low();
        peek(3'd3, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL add_wrap_r3: got %h expected 00", v); end
        drive(mk(OP_J, 8'hF9, 8'h00, 8'h00)); commit();
        n_checks++; if (bus.PC_OUT !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL j_wrap_pc: got %h expected fffffffc", bus.PC_OUT); end
        wait_low(); drive(mk(8'hFF, 8'h00, 8'h00, 8'h00)); commit();
        n_checks++; if (bus.PC_OUT !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h expected 0", bus.PC_OUT); end
    endtask

    // sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESET    = 1'b0;
        bus.INSTRUCTION = 32'h0;
        test_reset();
        test_loadi_add();
        test_logic_ops();
        test_branch();
        test_jump_nop();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_cpu_core.md
Name: simple_cpu_core

Overview:
- Single-cycle 8-bit processor core: program counter, next-PC logic, opcode decoder, 8x8 register file and 8-bit ALU.
- Fetches one 32-bit instruction per cycle from external instruction memory, addressed by PC_OUT.
- Executes the instruction in the same cycle; results commit on the next rising clock edge.
- Top-level datapath block of the simple processor; instruction memory sits outside it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-low (0 = reset asserted).
- INSTRUCTION  in  32  current instruction.
  - [7:0] opcode.
  - [10:8] destination register; [15:8] also carries the branch/jump offset.
  - [18:16] source register 1.
  - [26:24] source register 2; [31:24] also carries the immediate.
- PC_OUT  out  32  current instruction address.
- ALU_RESULT  out  8  combinational ALU result (observability).
- ZERO  out  1  combinational flag, 1 when ALU_RESULT == 0.

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC_OUT = RESET_PC; all 8 registers = 8'h00.
  - While reset is held, no register write and no PC update.
  - Release is sampled at the next rising edge.
- PC update on each rising edge when not in reset:
  - PC_next = PC+4, unless a taken branch or jump.
  - Taken branch or jump: PC_next = PC + 4 + (sign-extended INSTRUCTION[15:8] << 2).
  - Arithmetic is 32-bit and wraps modulo 2^32.
- Opcodes (hex), with control signals:
  - 00 loadi: write imm, ALUOP=FWD, operand2 = INSTRUCTION[31:24].
  - 01 mov: write, FWD, operand2 = reg[rs2].
  - 02 add: write, ADD.
  - 03 sub: write, ADD, operand2 = two's complement of reg[rs2].
  - 04 and: write, AND.
  - 05 or: write, OR.
  - 06 j: no write; always taken.
  - 07 beq: no write; computes rs1 - rs2; taken when ZERO=1.
  - 08 bne: no write; computes rs1 - rs2; taken when ZERO=0.
  - Any other opcode: NOP. No write, PC+4.
- ALU: operand1 is always reg[rs1]. ALUOP encoding:
  - 000 FWD: result = operand2.
  - 001 ADD: result = operand1 + operand2, mod 256; carry discarded.
  - 010 AND.
  - 011 OR.
  - Other codes: result 8'h00.
  - ZERO reflects the current result combinationally.
- Register file:
  - Two combinational read ports (rs1, rs2).
  - One synchronous write port (rd), written at the rising edge with ALU_RESULT when write is enabled.
  - Reading a register that is written in the same cycle returns the old value.
  - No register 0 hardwiring; all 8 are writable.
- Single-cycle: an instruction's write and PC change are visible after exactly one edge.
- The design has no delays; it is fully synthesizable.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_LOADI..OP_BNE);
  - ALUOP enum (FWD, ADD, AND, OR);
  - branch-control enum (NONE, BEQ, BNE).
- Sub-modules, one each:
  - cpu_alu: combinational ALU and ZERO;
  - cpu_regfile: 8x8 register file;
  - cpu_decode: opcode to control signals.
- PC register and next-PC adder stay in the top level.

Test Plan:
- Reset: hold RESET=0, apply an edge -> PC_OUT=0 and all registers 0; assert RESET mid-program -> PC_OUT returns to 0 immediately.
- loadi r1,5 then loadi r2,3, then add r3,r1,r2 -> ALU_RESULT=8; PC steps 0, 4, 8, 12.
- sub r4,r2,r1 (3-5) -> ALU_RESULT=8'hFE, ZERO=0; and/or of 8'hF0 with 8'h3C -> 8'h30 and 8'hFC; mov r5,r1 -> 5.
- beq r1,r1 offset 2 at PC=16 -> next PC 28; beq with unequal registers -> 20; bne at PC=16 with unequal registers, offset 8'hFE -> next PC 12.
- j offset 8'h01 at PC=0 -> next PC 8; undefined opcode 8'hFF -> no register change, PC+4.
- Wrap: add 8'hFF+8'h01 -> ALU_RESULT=0, ZERO=1; PC at 32'hFFFF_FFFC -> next PC 0.
